// File: rtl/uart_apb_pkg.sv
// uart_apb_pkg: register map, status/control bit positions and FSM encodings shared by
// the uart_apb master and its transfer engine.
package uart_apb_pkg;
   localparam logic [31:0] CTRL_OFF    = 32'h0;
   localparam logic [31:0] STATS_OFF   = 32'h4;
   localparam logic [31:0] TX_DATA_OFF = 32'h8;
   localparam logic [31:0] RX_DATA_OFF = 32'hC;
   localparam int TX_FULL_BIT  = 0;
   localparam int RX_AVAIL_BIT = 1;
   localparam int TX_EN_BIT    = 0;
   localparam int RX_EN_BIT    = 1;
   typedef enum logic [2:0] {S_INIT, S_IDLE, S_POLL, S_DECIDE, S_TX_WR, S_RX_RD} sched_state_t;
   typedef enum logic [1:0] {X_IDLE, X_SETUP, X_ACCESS} xfer_state_t;
endpackage

// File: rtl/apb_master_xfer.sv
// apb_master_xfer: runs one APB transfer per start (SETUP, then ACCESS until pready);
// done/rdata/slverr are valid in the completing ACCESS cycle.
module apb_master_xfer
   import uart_apb_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        write,
   output logic        idle,
   output logic        done,
   output logic [31:0] rdata,
   output logic        slverr,
   output logic [31:0] paddr,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] pwdata,
   input  logic [31:0] prdata,
   input  logic        pready,
   input  logic        pslverr
);
   xfer_state_t state, state_nxt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= X_IDLE;
      else state <= state_nxt;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         paddr  <= '0;
         pwdata <= '0;
         pwrite <= 1'b0;
      end else if (start && state == X_IDLE) begin
         paddr  <= addr;
         pwdata <= wdata;
         pwrite <= write;
      end
   end
   always_comb begin
      state_nxt = state;
      case (state)
         X_IDLE:   state_nxt = start ? X_SETUP : X_IDLE;
         X_SETUP:  state_nxt = X_ACCESS;
         X_ACCESS: state_nxt = pready ? X_IDLE : X_ACCESS;
         default:  state_nxt = X_IDLE;
      endcase
   end
   assign idle    = state == X_IDLE;
   assign psel    = state != X_IDLE;
   assign penable = state == X_ACCESS;
   assign done    = penable && pready;
   assign rdata   = prdata;
   assign slverr  = pslverr;
endmodule

// File: rtl/uart_apb_sched.sv
// uart_apb_sched: APB master that enables uart_apb, polls STATS, feeds TX from two
// round-robin requesters and drains RX bytes into a one-entry output buffer.
module uart_apb_sched
   import uart_apb_pkg::*;
#(
   parameter int unsigned POLL_CYCLES = 64,
   parameter logic [31:0] CTRL_INIT   = 32'((1 << TX_EN_BIT) | (1 << RX_EN_BIT)),
   parameter logic [31:0] BASE_ADDR   = 32'h0
)(
   input  logic        PCLK,
   input  logic        PRESETn,
   output logic [31:0] m_paddr,
   output logic        m_psel,
   output logic        m_penable,
   output logic        m_pwrite,
   output logic [31:0] m_pwdata,
   input  logic [31:0] m_prdata,
   input  logic        m_pready,
   input  logic        m_pslverr,
   input  logic        req0_valid,
   input  logic [7:0]  req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [7:0]  req1_data,
   output logic        req1_ready,
   output logic        rx_valid,
   output logic [7:0]  rx_data,
   input  logic        rx_ready,
   output logic        init_done,
   output logic        err
);
   localparam int TW = $clog2(POLL_CYCLES + 1);
   sched_state_t state, state_nxt;
   logic [TW-1:0] timer;
   logic rr, gnt, tx_full, rx_avail, any_req, win;
   logic [7:0] tx_byte;
   logic x_start, x_idle, x_done, x_slverr, x_write;
   logic [31:0] x_addr, x_wdata, x_rdata;
   assign any_req = req0_valid | req1_valid;
   assign win     = (req0_valid && req1_valid) ? rr : req1_valid;
   // a new transfer is launched whenever a bus state finds the engine idle, which also retries INIT
   assign x_start = x_idle && (state inside {S_INIT, S_POLL, S_TX_WR, S_RX_RD});
   assign x_write = state == S_INIT || state == S_TX_WR;
   assign x_wdata = state == S_INIT ? CTRL_INIT : {24'h0, tx_byte};
   assign x_addr  = BASE_ADDR + (state == S_INIT ? CTRL_OFF :
                                 state == S_POLL ? STATS_OFF :
                                 state == S_TX_WR ? TX_DATA_OFF : RX_DATA_OFF);
   apb_master_xfer u_xfer (
      .clk(PCLK), .rst_n(PRESETn), .start(x_start), .addr(x_addr), .wdata(x_wdata),
      .write(x_write), .idle(x_idle), .done(x_done), .rdata(x_rdata), .slverr(x_slverr),
      .paddr(m_paddr), .psel(m_psel), .penable(m_penable), .pwrite(m_pwrite),
      .pwdata(m_pwdata), .prdata(m_prdata), .pready(m_pready), .pslverr(m_pslverr)
   );
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state <= S_INIT;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:   if (x_done) state_nxt = x_slverr ? S_INIT : S_IDLE;
         S_IDLE:   if (any_req || timer == TW'(POLL_CYCLES - 1)) state_nxt = S_POLL;
         S_POLL:   if (x_done) state_nxt = x_slverr ? S_IDLE : S_DECIDE;
         S_DECIDE: state_nxt = (rx_avail && !rx_valid) ? S_RX_RD :
                               (!tx_full && any_req) ? S_TX_WR : S_IDLE;
         S_TX_WR:  if (x_done) state_nxt = S_IDLE;
         S_RX_RD:  if (x_done) state_nxt = S_IDLE;
         default:  state_nxt = S_INIT;
      endcase
   end
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         timer      <= '0;
         rr         <= 1'b0;
         gnt        <= 1'b0;
         tx_full    <= 1'b0;
         rx_avail   <= 1'b0;
         tx_byte    <= '0;
         rx_valid   <= 1'b0;
         rx_data    <= '0;
         init_done  <= 1'b0;
         err        <= 1'b0;
         req0_ready <= 1'b0;
         req1_ready <= 1'b0;
      end else begin
         timer      <= (state == S_IDLE && state_nxt == S_IDLE) ? timer + 1'b1 : '0;
         req0_ready <= 1'b0;
         req1_ready <= 1'b0;
         if (x_done && x_slverr) err <= 1'b1;
         if (rx_valid && rx_ready) rx_valid <= 1'b0;
         if (state == S_DECIDE) begin
            gnt     <= win;
            tx_byte <= win ? req1_data : req0_data;
         end
         if (x_done && !x_slverr) begin
            if (state == S_INIT) init_done <= 1'b1;
            if (state == S_POLL) {rx_avail, tx_full} <= {x_rdata[RX_AVAIL_BIT], x_rdata[TX_FULL_BIT]};
            if (state == S_TX_WR) begin
               req0_ready <= !gnt;
               req1_ready <= gnt;
               rr         <= !gnt;
            end
            if (state == S_RX_RD) begin
               rx_data  <= x_rdata[7:0];
               rx_valid <= 1'b1;
            end
         end
      end
   end
endmodule
